// File: rtl/counter_pkg.sv
// Shared constants for the counter: default width and the legal WIDTH range.
package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 8;
  localparam int COUNTER_MIN_WIDTH     = 1;
  localparam int COUNTER_MAX_WIDTH     = 32;

  // Used at elaboration time to reject unsupported widths.
  function automatic bit counter_width_ok(input int width);
    return (width >= COUNTER_MIN_WIDTH) && (width <= COUNTER_MAX_WIDTH);
  endfunction

endpackage : counter_pkg

// File: rtl/counter.sv
// WIDTH-bit up-counter with an at_max decode and a registered wrap pulse.
// Define COUNTER_SATURATE_EN to make the counter stop at its maximum value instead of wrapping.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr,
  output logic [WIDTH-1:0] count_reg,
  output logic             at_max,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  if (!counter_width_ok(WIDTH)) begin : g_width_check
    $error("counter: WIDTH=%0d outside legal range %0d..%0d",
           WIDTH, COUNTER_MIN_WIDTH, COUNTER_MAX_WIDTH);
  end

  assign at_max = (count_reg == MAX_COUNT);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      wrap      <= 1'b0;
    end else begin
`ifdef COUNTER_SATURATE_EN
      wrap <= 1'b0;
      if (incr && !at_max) begin
        count_reg <= count_reg + 1'b1;
      end
`else
      // Natural modulo overflow of the adder supplies the wrap to zero.
      wrap <= incr && at_max;
      if (incr) begin
        count_reg <= count_reg + 1'b1;
      end
`endif
    end
  end

endmodule : counter

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed sequences plus randomized stimulus against an arithmetic model.
// Runs a WIDTH=8 and a WIDTH=1 instance side by side; the model follows COUNTER_SATURATE_EN.
module tb_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       incr8;
  logic       incr1;
  logic [7:0] count8;
  logic       at_max8;
  logic       wrap8;
  logic [0:0] count1;
  logic       at_max1;
  logic       wrap1;

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain integers.
  int model_count8;
  int model_count1;
  bit model_wrap8;
  bit model_wrap1;

  counter #(.WIDTH(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .incr     (incr8),
    .count_reg(count8),
    .at_max   (at_max8),
    .wrap     (wrap8)
  );

  counter #(.WIDTH(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .incr     (incr1),
    .count_reg(count1),
    .at_max   (at_max1),
    .wrap     (wrap1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock's worth of counting rules, expressed arithmetically.
  task automatic model_advance(input bit inc, input int width, inout int cnt, output bit wrp);
    int max_val;
    max_val = (1 << width) - 1;
    wrp = 1'b0;
    if (inc) begin
      if (SATURATE) begin
        if (cnt < max_val) cnt = cnt + 1;
      end else begin
        wrp = (cnt == max_val);
        cnt = (cnt + 1) % (max_val + 1);
      end
    end
  endtask

  task automatic model_reset();
    model_count8 = 0;
    model_count1 = 0;
    model_wrap8  = 1'b0;
    model_wrap1  = 1'b0;
  endtask

  task automatic compare_all(input string phase);
    check({phase, ".count8"},  {24'd0, count8},  model_count8);
    check({phase, ".wrap8"},   {31'd0, wrap8},   {31'd0, model_wrap8});
    check({phase, ".at_max8"}, {31'd0, at_max8}, {31'd0, (model_count8 == 255)});
    check({phase, ".count1"},  {31'd0, count1},  model_count1);
    check({phase, ".wrap1"},   {31'd0, wrap1},   {31'd0, model_wrap1});
    check({phase, ".at_max1"}, {31'd0, at_max1}, {31'd0, (model_count1 == 1)});
  endtask

  // Advance one rising edge, update the model, and compare 1 ns later.
  task automatic cycle(input string phase);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_advance(incr8, 8, model_count8, model_wrap8);
      model_advance(incr1, 1, model_count1, model_wrap1);
    end
    #1;
    compare_all(phase);
  endtask

  initial begin
    rst   = 1'b0;
    incr8 = 1'b0;
    incr1 = 1'b0;
    #1;
    rst   = 1'b1;
    incr8 = 1'b1;
    incr1 = 1'b1;
    #1;
    model_reset();
    compare_all("reset_async");

    // Reset held across edges with incr high.
    repeat (2) cycle("reset_hold");

    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle("count_up");
      check("count_up.const", {24'd0, count8}, i);
    end

    incr8 = 1'b0;
    repeat (4) begin
      cycle("hold");
      check("hold.const", {24'd0, count8}, 32'd4);
    end

    // Reset between edges must clear the count before the next rising edge.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("reset_mid");
    check("reset_mid.const", {24'd0, count8}, 32'd0);
    cycle("reset_mid_edge");
    rst = 1'b0;

    incr8 = 1'b1;
    repeat (255) cycle("preload");
    check("preload.count255", {24'd0, count8}, 32'd255);
    check("preload.at_max", {31'd0, at_max8}, 32'd1);
    cycle("wrap_edge");
    check("wrap_edge.count", {24'd0, count8}, SATURATE ? 32'd255 : 32'd0);
    check("wrap_edge.wrap", {31'd0, wrap8}, SATURATE ? 32'd0 : 32'd1);
    incr8 = 1'b0;
    cycle("after_wrap");
    check("after_wrap.wrap", {31'd0, wrap8}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      incr8 = ($urandom_range(0, 3) != 0);
      incr1 = ($urandom_range(0, 2) != 0);
      cycle("random");
    end

    rst   = 1'b0;
    incr8 = 1'b1;
    incr1 = 1'b1;
    repeat (300) cycle("tail_run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: WIDTH, default 8, counter bit width; legal range 1 to 32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 incr  input  1  increment enable; sampled on rising clk.
REQ-005 count_reg  output  WIDTH  current count, driven directly from a register.
REQ-006 at_max  output  1  high while count_reg equals 2^WIDTH-1, combinational decode of count_reg.
REQ-007 wrap  output  1  registered one-cycle pulse, high in the cycle after count_reg steps from 2^WIDTH-1 to 0.

Function
REQ-008 On a rising clk with rst low and incr high, count_reg SHALL become count_reg+1 modulo 2^WIDTH.
REQ-009 On a rising clk with rst low and incr low, count_reg SHALL hold its value.
REQ-010 Latency: a change on incr SHALL affect count_reg at the first rising clk that samples it, with no additional pipeline stage.
REQ-011 Wrap-around: with incr high at count_reg = 2^WIDTH-1, count_reg SHALL become 0 and wrap SHALL be 1 for exactly that following cycle.
REQ-012 wrap SHALL be 0 in every cycle that does not directly follow a wrap event.
REQ-013 rst high together with incr high SHALL keep count_reg at 0; reset has priority over incr.
REQ-014 Outputs SHALL contain no X after the first reset assertion, regardless of incr value.

Reset
REQ-015 Asserting rst SHALL immediately, independent of clk, force count_reg to 0 and wrap to 0; at_max follows as 0 for WIDTH >= 1.
REQ-016 While rst is high, count_reg SHALL remain 0 across any number of clk edges.
REQ-017 After rst deasserts, the first rising clk with incr high SHALL produce count_reg = 1.
REQ-018 Reset mid-count SHALL discard the current value with no residual state.

Configuration
REQ-019 Macro COUNTER_SATURATE_EN: when defined, count_reg SHALL stop at 2^WIDTH-1 while incr stays high, and wrap SHALL stay 0 permanently.
REQ-020 Without COUNTER_SATURATE_EN, the modulo wrap behaviour of REQ-011 SHALL apply.
REQ-021 The macro SHALL affect no port, width or reset value.

Structure
REQ-022 Package counter_pkg SHALL hold the default width constant (8) and the WIDTH legality bounds (1, 32); counter SHALL import it.
REQ-023 No sub-module: a single register stage plus next-state logic and the at_max decode; an elaboration-time check SHALL reject WIDTH outside 1 to 32.

Verification
REQ-024 Hold rst high for 2 cycles with incr = 1 -> count_reg = 0 throughout; wrap = 0.
REQ-025 Release rst with incr = 1 for 4 rising edges -> count_reg = 1, 2, 3, 4.
REQ-026 Drop incr to 0 for 4 rising edges -> count_reg holds 4.
REQ-027 Assert rst mid-cycle between edges at count_reg = 4 -> count_reg = 0 before the next rising clk.
REQ-028 WIDTH = 8: preload to 255 by 255 increments, then one more increment -> count_reg = 0, wrap = 1 for one cycle; at_max = 1 at 255. With COUNTER_SATURATE_EN -> count_reg stays 255, wrap = 0.
REQ-029 WIDTH = 1 with incr held high -> count_reg toggles 0, 1, 0; wrap pulses each time 1 goes to 0 (non-saturating build).
